// File: rtl/dct_da_engine_pkg.sv
// dct_da_engine shared package
// cosine table, DA ROM helper, FSM state
package dct_pkg;

  localparam int N_PT = 8;

  localparam int COS_Q15 [N_PT][N_PT] = '{
    '{ 11585,  11585,  11585,  11585,
       11585,  11585,  11585,  11585},
    '{ 16069,  13623,   9102,   3196,
       -3196,  -9102, -13623, -16069},
    '{ 15137,   6270,  -6270, -15137,
      -15137,  -6270,   6270,  15137},
    '{ 13623,  -3196, -16069,  -9102,
        9102,  16069,   3196, -13623},
    '{ 11585, -11585, -11585,  11585,
       11585, -11585, -11585,  11585},
    '{  9102, -16069,   3196,  13623,
      -13623,  -3196,  16069,  -9102},
    '{  6270, -15137,  15137,  -6270,
       -6270,  15137, -15137,   6270},
    '{  3196,  -9102,  13623, -16069,
       16069, -13623,   9102,  -3196}
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int da_rom(
    input int k,
    input int h,
    input int addr,
    input int coef_w
  );
    int s;
    int frac;
    s = 0;
    for (int j = 0; j < 4; j++) begin
      if (addr[j]) s += COS_Q15[k][4*h+j];
    end
    frac = coef_w - 2;
    if (frac >= 15) begin
      da_rom = s <<< (frac - 15);
    end else begin
      da_rom = (s + (1 <<< (14 - frac)))
               >>> (15 - frac);
    end
  endfunction

endpackage

// File: rtl/dct_da_engine_if.sv
// dct_da_engine block handshake bundle
// sample input and coefficient output channels
interface dct_da_engine_if #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 17,
  parameter int NCOEF  = 8
);
  localparam int OUT_W = COEF_W + IN_W;

  logic                   in_valid;
  logic                   in_ready;
  logic [8*IN_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCOEF*OUT_W-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

endinterface

// File: rtl/dct_da_lane.sv
// dct_da_engine single coefficient lane
// split ROM pair, term adder, accumulator
module dct_da_lane
  import dct_pkg::*;
#(
  parameter int K      = 0,
  parameter int IN_W   = 8,
  parameter int COEF_W = 17,
  parameter int OUT_W  = 25,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic             last,
  input  logic [CNT_W-1:0] bit_cnt,
  input  logic [3:0]       addr_lo,
  input  logic [3:0]       addr_hi,
  output logic [OUT_W-1:0] acc_nxt
);

  localparam int RW = 16 * COEF_W;

  function automatic logic [RW-1:0] rom_init(
    input int h
  );
    logic [RW-1:0] r;
    int w;
    r = '0;
    for (int a = 0; a < 16; a++) begin
      w = da_rom(K, h, a, COEF_W);
      r[a*COEF_W +: COEF_W] = COEF_W'(w);
    end
    rom_init = r;
  endfunction

  localparam logic [RW-1:0] ROM0 = rom_init(0);
  localparam logic [RW-1:0] ROM1 = rom_init(1);

  logic [COEF_W-1:0] lo_w;
  logic [COEF_W-1:0] hi_w;
  logic [COEF_W:0]   term;
  logic [OUT_W-1:0]  sh;
  logic [OUT_W-1:0]  acc_q;
  logic [OUT_W-1:0]  acc_d;

  // ROM lookup and weighted term
  always_comb begin
    lo_w = ROM0[int'(addr_lo)*COEF_W +: COEF_W];
    hi_w = ROM1[int'(addr_hi)*COEF_W +: COEF_W];
    term = {lo_w[COEF_W-1], lo_w}
         + {hi_w[COEF_W-1], hi_w};
    sh   = {{(OUT_W-COEF_W-1){term[COEF_W]}},
            term} << bit_cnt;
  end

  // accumulate; sign bit weight is negative
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = last ? acc_q - sh : acc_q + sh;
    end
    acc_nxt = acc_d;
  end

  // accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/dct_da_engine.sv
// dct_da_engine bit-serial DA 8-point DCT
// FSM, bit counter, sample shifters, handshake
module dct_da_engine
  import dct_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int COEF_W = 17,
  parameter int NCOEF  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  dct_da_engine_if.slave bus
);

  localparam int OUT_W = COEF_W + IN_W;
  localparam int CNT_W =
    (IN_W > 1) ? $clog2(IN_W) : 1;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [IN_W-1:0]        smp_q [N_PT];
  logic [IN_W-1:0]        smp_d [N_PT];
  logic                   out_valid_q, out_valid_d;
  logic [NCOEF*OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0]       acc_nxt [NCOEF];
  logic                   in_ready;
  logic                   accept;
  logic                   retire;
  logic                   step;
  logic                   last;
  logic [3:0]             addr_lo;
  logic [3:0]             addr_hi;

  // handshake and step qualifiers
  always_comb begin
    accept = en & bus.in_valid & in_ready;
    retire = en & (state_q == DONE)
           & bus.out_ready;
    step   = en & (state_q == RUN);
    last   = bit_cnt_q == CNT_W'(IN_W-1);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (step && last) state_d = DONE;
      DONE: begin
        if (accept)      state_d = RUN;
        else if (retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = 1'b0;
      DONE:    in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // current serial bit of each sample
  always_comb begin
    addr_lo = '0;
    addr_hi = '0;
    for (int j = 0; j < 4; j++) begin
      addr_lo[j] = smp_q[j][0];
      addr_hi[j] = smp_q[j+4][0];
    end
  end

  // datapath next values
  always_comb begin
    smp_d       = smp_q;
    bit_cnt_d   = bit_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (retire) out_valid_d = 1'b0;
    if (accept) begin
      for (int i = 0; i < N_PT; i++) begin
        smp_d[i] = bus.in_data[i*IN_W +: IN_W];
      end
      bit_cnt_d = '0;
    end else if (step) begin
      for (int i = 0; i < N_PT; i++) begin
        smp_d[i] = smp_q[i] >> 1;
      end
      bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
      if (last) begin
        out_valid_d = 1'b1;
        for (int k = 0; k < NCOEF; k++) begin
          out_data_d[k*OUT_W +: OUT_W] =
            acc_nxt[k];
        end
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < N_PT; i++) begin
        smp_q[i] <= '0;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      smp_q       <= smp_d;
    end
  end

  for (genvar k = 0; k < NCOEF; k++) begin : g_lane
    dct_da_lane #(
      .K      (k),
      .IN_W   (IN_W),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .step    (step),
      .last    (last),
      .bit_cnt (bit_cnt_q),
      .addr_lo (addr_lo),
      .addr_hi (addr_hi),
      .acc_nxt (acc_nxt[k])
    );
  end

endmodule

// File: tb/tb_dct_da_engine.sv
// tb_dct_da_engine scoreboard bench
// directed blocks, decoupled output monitor
module tb_dct_da_engine;

  localparam int IN_W   = 8;
  localparam int COEF_W = 17;
  localparam int NCOEF  = 8;
  localparam int OUT_W  = COEF_W + IN_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  dct_da_engine_if #(
    .IN_W(IN_W), .COEF_W(COEF_W), .NCOEF(NCOEF)
  ) bus ();

  dct_da_engine #(
    .IN_W(IN_W), .COEF_W(COEF_W), .NCOEF(NCOEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  typedef struct {
    int x [8];
    int lat;
  } exp_t;

  exp_t expq [$];
  int   acc_t [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string name,
    input int    got,
    input int    want
  );
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d",
               name, got, want);
    end
  endtask

  function automatic int lane(input int k);
    logic [OUT_W-1:0] v;
    v = bus.out_data[k*OUT_W +: OUT_W];
    lane = int'($signed(v));
  endfunction

  function automatic void model(
    input  int s [8],
    output int x [8]
  );
    real pi, c, v;
    int  ck;
    pi = 3.14159265358979;
    for (int k = 0; k < 8; k++) begin
      c = (k == 0) ? 0.5 / $sqrt(2.0) : 0.5;
      x[k] = 0;
      for (int i = 0; i < 8; i++) begin
        v  = c * $cos((2*i+1)*k*pi/16.0)
           * 32768.0;
        ck = $rtoi($floor(v + 0.5));
        x[k] += s[i] * ck;
      end
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready && en)
        acc_t.push_back(cyc + 1);
      if (bus.out_valid && !ov_prev) begin
        if (expq.size() == 0 ||
            acc_t.size() == 0)
          check("unexpected_out", 1, 0);
        else
          check("latency",
                cyc - acc_t.pop_front(),
                expq[0].lat);
      end
      if (bus.out_valid && bus.out_ready
          && en) begin
        if (expq.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          e = expq.pop_front();
          for (int k = 0; k < NCOEF; k++)
            check($sformatf("X%0d", k),
                  lane(k), e.x[k]);
        end
      end
    end
    ov_prev <= bus.out_valid;
  end

  task automatic send(
    input int s   [8],
    input int ex  [8],
    input int lat
  );
    exp_t e;
    int   n;
    for (int i = 0; i < 8; i++)
      bus.in_data[i*IN_W +: IN_W] = IN_W'(s[i]);
    bus.in_valid = 1'b1;
    e.x   = ex;
    e.lat = lat;
    expq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.in_ready && en) && n < 200);
    if (n >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0)
      check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input int s [8]);
    int x [8];
    model(s, x);
    send(s, x, 8);
  endtask

  initial begin : main
    int s [8];
    int x [8];
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    en            = 1'b1;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data_x0", lane(0), 0);
    check("rst_out_data_x7", lane(7), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_bit_cnt", 32'(dut.bit_cnt_q), 0);

    s = '{0, 0, 0, 0, 0, 0, 0, 0};
    x = '{0, 0, 0, 0, 0, 0, 0, 0};
    send(s, x, 8);

    s = '{1, 1, 1, 1, 1, 1, 1, 1};
    x = '{92680, 0, 0, 0, 0, 0, 0, 0};
    send(s, x, 8);

    s = '{-128, -128, -128, -128,
          -128, -128, -128, -128};
    x = '{-11863040, 0, 0, 0, 0, 0, 0, 0};
    send(s, x, 8);

    s = '{1, 0, 0, 0, 0, 0, 0, 0};
    x = '{11585, 16069, 15137, 13623,
          11585, 9102, 6270, 3196};
    send(s, x, 8);

    s = '{10, -20, 30, -40, 50, -60, 70, -128};
    send_m(s);
    s = '{127, 127, 127, 127,
          127, 127, 127, 127};
    send_m(s);
    s = '{-1, 2, -3, 4, -5, 6, -7, 8};
    send_m(s);
    drain();

    bus.out_ready = 1'b0;
    s = '{3, -7, 100, -100, 64, 0, -1, 127};
    send_m(s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    if (n >= 50) check("stall_timeout", 0, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_ready", 32'(bus.in_ready), 0);
      if (expq.size() > 0) begin
        for (int k = 0; k < NCOEF; k++)
          check("stall_data", lane(k),
                expq[0].x[k]);
      end
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    s = '{-50, 25, -12, 6, -3, 1, 0, 90};
    send_m(s);
    drain();

    s = '{7, 6, 5, 4, 3, 2, 1, 0};
    model(s, x);
    send(s, x, 11);
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    drain();

    s = '{9, -9, 9, -9, 9, -9, 9, -9};
    send_m(s);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_ready", 32'(bus.in_ready), 1);
    check("mid_rst_x0", lane(0), 0);
    check("mid_rst_x1", lane(1), 0);
    expq.delete();
    acc_t.delete();
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 1);

    s = '{1, 0, 0, 0, 0, 0, 0, 0};
    x = '{11585, 16069, 15137, 13623,
          11585, 9102, 6270, 3196};
    send(s, x, 8);
    drain();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
